rs_syndrome_calc: RTL and testbench
===================================

// Module: rs_syndrome_calc
// PURPOSE
//  Receive-side stage downstream of the RS(15,9) encoder over GF(16).
//  Takes one 60-bit codeword (15 x 4-bit symbols) and computes syndromes
//  S1..S6 by Horner evaluation of r(x) at alpha^1..alpha^6, one symbol per clock.
//  Flags any nonzero syndrome and hands the syndromes to the later key-equation solver.
// PARAMETERS
//  SYM_W   4   symbol width, bits. Only 4 is supported.
//  N_SYM   15  codeword length, symbols. Only 15 is supported.
//  N_SYND  6   number of syndromes (2t, t=3). Only 6 is supported.
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  codeword       in   60  received word; [59:56]=c14 (highest degree) ... [3:0]=c0
//  startSyndrome  in   1   one-cycle start request, sampled on clk
//  syndromeBusy   out  1   high while symbols are being accumulated
//  syndromeDone   out  1   one-cycle pulse when syndromes are valid
//  syndromes      out  24  S_j at [4j-1:4j-4], so S1=[3:0] ... S6=[23:20]
//  errorDetected  out  1   |syndromes; valid from syndromeDone, held until next accept
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst).
//  - Field: GF(16), primitive poly x^4+x+1, alpha=4'b0010, bit3 = x^3 coefficient.
//  - Reset: state=IDLE, syndromeBusy=0, syndromeDone=0, syndromes=0, errorDetected=0,
//    symbol counter=0, shift reg=0. rst overrides all other inputs, including mid-ACCUM;
//    no syndromeDone is produced for an aborted word.
//  - States:
//    IDLE: waits for startSyndrome.
//    ACCUM: accumulates one symbol per clock.
//    DONE: lasts exactly one cycle.
//  - Accept: startSyndrome=1 in IDLE or DONE at edge E0.
//    At E0: codeword is latched into the shift reg, S1..S6 clear to 0, counter clears to 0,
//    state goes to ACCUM, and syndromeBusy goes to 1.
//  - ACCUM, each edge: S_j <= gfmul(S_j, alpha^j) ^ sym, for j=1..6.
//    sym is the top symbol of the shift reg. Shift left 4, counter++.
//    Symbols are consumed c14 first, c0 last.
//  - After 15 ACCUM edges (E1..E15): state=DONE, syndromeBusy=0, syndromeDone=1,
//    errorDetected=|S. Latency: start sampled at E0, done high in the cycle after E15.
//  - DONE -> IDLE on the next edge unless startSyndrome=1, which is accepted (back-to-back).
//    Minimum accept-to-accept spacing is 16 clocks.
//  - startSyndrome while syndromeBusy=1 is ignored. The word in flight is unaffected.
//  - codeword is sampled only at accept; later changes have no effect on the result.
//  - syndromes/errorDetected hold their last result from DONE until the next accept.
//    They show partial values during ACCUM; consumers qualify with syndromeDone.
//  - gfmul by constants alpha^1..alpha^6 is pure XOR logic; no lookup tables, no latches.
// TESTING
//  1 rst held 3 clk -> all outputs 0, state IDLE; start during rst ignored.
//  2 codeword=60'h0, start -> done 16 clk after start; syndromes=24'h000000,
//    errorDetected=0.
//  3 codeword=60'h000000000000001 (c0=1) -> syndromes=24'h111111, errorDetected=1.
//  4 codeword=60'h000000000000010 (c1=1) -> syndromes=24'hC63842.
//    codeword=60'h100000000000000 (c14=1) -> syndromes=24'hA7EFD9.
//  5 encoder output for message 36'h0000000E7, fed directly -> syndromes=0.
//    Same word with [31:28] XOR 4'h5 -> errorDetected=1.
//  6 start pulse at cycle 5 of ACCUM -> ignored, result unchanged.
//    rst at cycle 8 of ACCUM -> no done, IDLE.
//    start on the DONE cycle -> new word accepted, busy next cycle.

Source files
------------

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) receive-side syndrome stage over GF(16) using x^4+x+1.
// Horner-evaluates the received word at alpha^1..alpha^6, taking one symbol per clock and c14 first.
module rs_syndrome_calc #(
   parameter int SYM_W  = 4,
   parameter int N_SYM  = 15,
   parameter int N_SYND = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SYM_W*N_SYM-1:0]    codeword,
   input  logic                      startSyndrome,
   output logic                      syndromeBusy,
   output logic                      syndromeDone,
   output logic [SYM_W*N_SYND-1:0]   syndromes,
   output logic                      errorDetected
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [SYM_W*N_SYM-1:0]     shreg_q, shreg_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [SYM_W*N_SYND-1:0]    synd_q, synd_d;
   logic                       err_q, err_d;
   logic [SYM_W*N_SYND-1:0]    synd_step;
   logic [SYM_W-1:0]           sym;
   logic                       accept;

   // Multiply by alpha: a shift, with x^4 folded back in as x+1.
   function automatic logic [3:0] gf_xtime(input logic [3:0] a);
      return {a[2], a[1], a[0] ^ a[3], a[3]};
   endfunction

   assign sym    = shreg_q[SYM_W*N_SYM-1 -: SYM_W];
   assign accept = startSyndrome && (state_q != S_ACCUM);

   // Horner step: S_j becomes S_j * alpha^j ^ sym, built from j chained xtime stages.
   always_comb begin : horner
      logic [SYM_W-1:0] t;
      synd_step = '0;
      for (int j = 0; j < N_SYND; j++) begin
         t = synd_q[SYM_W*j +: SYM_W];
         for (int k = 0; k < N_SYND; k++) begin
            if (k <= j) t = gf_xtime(t);
         end
         synd_step[SYM_W*j +: SYM_W] = t ^ sym;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      synd_d  = synd_q;
      err_d   = err_q;
      if (accept) begin
         state_d = S_ACCUM;
         shreg_d = codeword;
         cnt_d   = 4'd0;
         synd_d  = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ACCUM: begin
               shreg_d = shreg_q << SYM_W;
               cnt_d   = cnt_q + 4'd1;
               synd_d  = synd_step;
               if (cnt_q == 4'(N_SYM - 1)) begin
                  state_d = S_DONE;
                  err_d   = |synd_step;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= 4'd0;
         synd_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         synd_q  <= synd_d;
         err_q   <= err_d;
      end
   end

   assign syndromeBusy  = (state_q == S_ACCUM);
   assign syndromeDone  = (state_q == S_DONE);
   assign syndromes     = synd_q;
   assign errorDetected = err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: known syndrome vectors, latency, start/reset corner cases.
module tb_rs_syndrome_calc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [59:0] codeword = '1;
   logic        start = 1'b1;
   logic        busy, done, err;
   logic [23:0] synd;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [24:0] exp_q[$];

   rs_syndrome_calc dut (
      .clk           (clk),
      .rst           (rst),
      .codeword      (codeword),
      .startSyndrome (start),
      .syndromeBusy  (busy),
      .syndromeDone  (done),
      .syndromes     (synd),
      .errorDetected (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] t;
      p = 4'h0;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
      end
      return p;
   endfunction

   // Systematic RS(15,9) encoder: generator has roots alpha^1..alpha^6.
   function automatic logic [59:0] rs_encode(input logic [35:0] msg);
      logic [3:0] g[0:6];
      logic [3:0] p[0:5];
      logic [3:0] aj;
      logic [3:0] fb;
      for (int k = 0; k < 7; k++) g[k] = 4'h0;
      for (int k = 0; k < 6; k++) p[k] = 4'h0;
      g[0] = 4'h1;
      aj   = 4'h1;
      for (int j = 1; j <= 6; j++) begin
         aj = gf_mul(aj, 4'h2);
         for (int k = j; k >= 0; k--) begin
            if (k > 0) g[k] = g[k-1] ^ gf_mul(g[k], aj);
            else       g[0] = gf_mul(g[0], aj);
         end
      end
      for (int i = 8; i >= 0; i--) begin
         fb = msg[4*i +: 4] ^ p[5];
         for (int k = 5; k >= 1; k--) p[k] = p[k-1] ^ gf_mul(fb, g[k]);
         p[0] = gf_mul(fb, g[0]);
      end
      return {msg, p[5], p[4], p[3], p[2], p[1], p[0]};
   endfunction

   task automatic drive_start(input logic [59:0] cw);
      codeword = cw;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Mode 1 injects a start pulse with a junk word during accumulation.
   task automatic wait_done(input int mode, output int cyc);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = (mode == 1 && cyc == 5);
         if (cyc == 3 || (mode == 1 && cyc == 5)) codeword = ~codeword;
      end
      start = 1'b0;
      if (cyc >= 40) check("timeout", done, 1'b1);
   endtask

   task automatic check_result(input string tag);
      logic [24:0] e;
      e = exp_q.pop_front();
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_synd"}, synd, e[23:0]);
      check({tag, "_err"}, err, e[24]);
   endtask

   task automatic run_word(input string tag, input logic [59:0] cw, input logic [23:0] s,
                           input logic e, input int mode);
      int lat;
      exp_q.push_back({e, s});
      @(negedge clk);
      drive_start(cw);
      check({tag, "_busy"}, busy, 1'b1);
      wait_done(mode, lat);
      check({tag, "_lat"}, lat, 16);
      check_result(tag);
   endtask

   initial begin
      logic [59:0] enc;
      int lat;
      int seen_done;

      // Reset held 3 clocks with start asserted the whole time.
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_synd", synd, 24'h0);
      check("rst_err", err, 1'b0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_rst_idle", busy, 1'b0);

      run_word("zero", 60'h0, 24'h000000, 1'b0, 0);
      run_word("c0", 60'h000000000000001, 24'h111111, 1'b1, 0);
      run_word("c1", 60'h000000000000010, 24'hC63842, 1'b1, 0);
      run_word("c14", 60'h100000000000000, 24'hA7EFD9, 1'b1, 0);

      enc = rs_encode(36'h0000000E7);
      check("enc_msg", enc[59:24], 36'h0000000E7);
      run_word("enc", enc, 24'h000000, 1'b0, 0);
      enc[31:28] = enc[31:28] ^ 4'h5;
      run_word("enc_err", enc, 24'h6DC9B1, 1'b1, 0);

      // Start during accumulation is ignored; codeword also toggled mid-word.
      run_word("ign_start", 60'h000000000000010, 24'hC63842, 1'b1, 1);

      // Syndromes hold after done while idle.
      repeat (3) begin
         @(negedge clk);
         codeword = ~codeword;
      end
      check("hold_synd", synd, 24'hC63842);
      check("hold_err", err, 1'b1);
      check("hold_idle", busy | done, 1'b0);

      // Reset at cycle 8 of accumulation aborts the word.
      @(negedge clk);
      drive_start(60'h000000000000001);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_synd", synd, 24'h0);
      check("abort_err", err, 1'b0);
      seen_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      check("abort_no_done", seen_done, 0);

      // Back-to-back: next word accepted on the done cycle.
      run_word("b2b_a", 60'h100000000000000, 24'hA7EFD9, 1'b1, 0);
      exp_q.push_back({1'b1, 24'h111111});
      drive_start(60'h000000000000001);
      check("b2b_busy", busy, 1'b1);
      check("b2b_not_done", done, 1'b0);
      wait_done(0, lat);
      check("b2b_lat", lat, 16);
      check_result("b2b_b");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
